fx2_fifo_ctrl: RTL

FPGA-side controller for the FX2 synchronous slave-FIFO bus. It sequences SLOE/SLRD/SLWR/PKTEND, the FIFO address and the FD bus direction. It arbitrates the single 16-bit FD bus between the host→FPGA stream (EP2 OUT) and the FPGA→host stream (EP6 IN), and presents both streams as valid/ready interfaces. It sits between the `fpga` top-level pins and the HostInterface command/data logic.

---
 rtl/fx2_fifo_ctrl_if.sv | 31 +++
 rtl/fx2_fifo_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fx2_fifo_ctrl_if.sv
// Stream side of the FX2 slave-FIFO controller.
// rx_*: words read from EP2; tx_*: words written to EP6.
interface fx2_fifo_ctrl_if;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] tx_data;
  logic        tx_last;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  tx_data,
    input  tx_last,
    input  tx_valid,
    output tx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output tx_data,
    output tx_last,
    output tx_valid,
    input  tx_ready
  );
endinterface

// File: rtl/fx2_fifo_ctrl.sv
// FX2 slave-FIFO controller: arbitrates FD between EP2 OUT and EP6 IN.
// Ports: ifclk/resetb, fx2_* pins, strm = rx/tx valid-ready streams.
module fx2_fifo_ctrl #(
  parameter int BURST_MAX = 256
) (
  input  logic        ifclk,
  input  logic        resetb,
  input  logic [2:0]  fx2_flags,
  input  logic [15:0] fx2_fd_in,
  output logic [15:0] fx2_fd_out,
  output logic        fx2_fd_oe,
  output logic        fx2_sloe_b,
  output logic        fx2_slrd_b,
  output logic        fx2_slwr_b,
  output logic        fx2_pktend_b,
  output logic [1:0]  fx2_fifo_addr,
  fx2_fifo_ctrl_if.master strm
);

  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(BURST_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_SETUP,
    S_RD,
    S_WR_SETUP,
    S_WR,
    S_PKTEND
  } state_t;

  state_t r_state, w_state;
  logic          r_ph, w_ph;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_lg, w_lg;
  logic          r_last, w_last;
  logic          r_sloe, w_sloe;
  logic          r_slrd, w_slrd;
  logic          r_slwr, w_slwr;
  logic          r_pkt, w_pkt;
  logic [1:0]    r_addr, w_addr;
  logic          r_oe, w_oe;
  logic [15:0]   r_fdo, w_fdo;
  logic [15:0]   r_rxd, w_rxd;
  logic          r_rxv, w_rxv;

  logic          w_rx_req;
  logic          w_tx_req;
  logic          w_cmax;
  logic [CW-1:0] w_cinc;
  logic          w_unused;

  assign w_unused = fx2_flags[2];
  assign w_rx_req = fx2_flags[0]
                  & (~r_rxv | strm.rx_ready);
  assign w_tx_req = strm.tx_valid & fx2_flags[1];
  assign w_cmax   = (r_cnt == CMAX);
  assign w_cinc   = w_cmax ? r_cnt : r_cnt + 1'b1;

  assign strm.tx_ready = (r_state == S_WR) & ~r_ph
                       & w_tx_req & ~w_cmax;
  assign strm.rx_data  = r_rxd;
  assign strm.rx_valid = r_rxv;

  assign fx2_fd_out    = r_fdo;
  assign fx2_fd_oe     = r_oe;
  assign fx2_sloe_b    = r_sloe;
  assign fx2_slrd_b    = r_slrd;
  assign fx2_slwr_b    = r_slwr;
  assign fx2_pktend_b  = r_pkt;
  assign fx2_fifo_addr = r_addr;

  always_comb begin
    w_state = r_state;
    w_ph    = r_ph;
    w_cnt   = r_cnt;
    w_lg    = r_lg;
    w_last  = r_last;
    w_sloe  = r_sloe;
    w_slrd  = 1'b1;
    w_slwr  = 1'b1;
    w_pkt   = 1'b1;
    w_addr  = r_addr;
    w_oe    = r_oe;
    w_fdo   = r_fdo;
    w_rxd   = r_rxd;
    w_rxv   = r_rxv;
    if (r_rxv && strm.rx_ready)
      w_rxv = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // r_lg = 1 means TX had the last grant
        if (w_rx_req && (!w_tx_req || r_lg)) begin
          w_state = S_RD_SETUP;
          w_lg    = 1'b0;
          w_cnt   = '0;
        end else if (w_tx_req) begin
          w_state = S_WR_SETUP;
          w_lg    = 1'b1;
          w_cnt   = '0;
        end
      end
      S_RD_SETUP: begin
        w_addr  = 2'b00;
        w_sloe  = 1'b0;
        w_oe    = 1'b0;
        w_ph    = 1'b0;
        w_state = S_RD;
      end
      S_RD: begin
        if (!r_ph) begin
          if (!fx2_flags[0] || w_cmax
              || (r_rxv && !strm.rx_ready)) begin
            w_state = S_IDLE;
            w_sloe  = 1'b1;
          end else begin
            w_slrd = 1'b0;
            w_ph   = 1'b1;
          end
        end else begin
          w_rxd = fx2_fd_in;
          w_rxv = 1'b1;
          w_cnt = w_cinc;
          w_ph  = 1'b0;
        end
      end
      S_WR_SETUP: begin
        w_sloe  = 1'b1;
        w_addr  = 2'b10;
        w_oe    = 1'b1;
        w_ph    = 1'b0;
        w_state = S_WR;
      end
      S_WR: begin
        if (!r_ph) begin
          if (!w_tx_req || w_cmax) begin
            w_state = S_IDLE;
            w_oe    = 1'b0;
          end else begin
            w_fdo  = strm.tx_data;
            w_slwr = 1'b0;
            w_last = strm.tx_last;
            w_ph   = 1'b1;
          end
        end else begin
          w_cnt = w_cinc;
          w_ph  = 1'b0;
          // commit needs no FIFO space, so no flag check
          if (r_last) begin
            w_state = S_PKTEND;
            w_pkt   = 1'b0;
          end
        end
      end
      S_PKTEND: begin
        w_state = S_IDLE;
        w_oe    = 1'b0;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      r_state <= S_IDLE;
      r_ph    <= 1'b0;
      r_cnt   <= '0;
      r_lg    <= 1'b1;
      r_last  <= 1'b0;
      r_sloe  <= 1'b1;
      r_slrd  <= 1'b1;
      r_slwr  <= 1'b1;
      r_pkt   <= 1'b1;
      r_addr  <= 2'b00;
      r_oe    <= 1'b0;
      r_fdo   <= '0;
      r_rxd   <= '0;
      r_rxv   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ph    <= w_ph;
      r_cnt   <= w_cnt;
      r_lg    <= w_lg;
      r_last  <= w_last;
      r_sloe  <= w_sloe;
      r_slrd  <= w_slrd;
      r_slwr  <= w_slwr;
      r_pkt   <= w_pkt;
      r_addr  <= w_addr;
      r_oe    <= w_oe;
      r_fdo   <= w_fdo;
      r_rxd   <= w_rxd;
      r_rxv   <= w_rxv;
    end
  end

endmodule
